// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl
//   Instruction-fetch sequencer for a synchronous instruction bank with a 1-cycle registered read.
//   Owns the PC, issues memread/address, absorbs the read latency in a small fetch buffer and
//   presents instructions to decode over a valid/ready handshake. Handles redirect, halt and
//   out-of-range fetch detection.
//
//   Optional feature macro: IFETCH_PERF_EN (adds stall_cnt / bubble_cnt performance counters).
//
// Ports
//   clk, rst_n        clock; asynchronous active-low reset
//   memread, address  read strobe and word-aligned byte address to the bank
//   readdata          bank data, valid the cycle after memread=1
//   if_valid/if_ready decode handshake; if_instr / if_pc carry the head instruction and its address
//   redirect_valid/pc single-cycle redirect; target bits [1:0] are ignored
//   halt_req          level; no new reads while high
//   fetch_err         sticky out-of-range flag, cleared by redirect or reset
//   stall_cnt         (IFETCH_PERF_EN) cycles with if_valid && !if_ready
//   bubble_cnt        (IFETCH_PERF_EN) RUN cycles with !if_valid && if_ready
module imem_fetch_ctrl #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned FB_DEPTH   = 2,
   parameter int unsigned ADDR_LIMIT = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        memread,
   output logic [31:0] address,
   input  logic [31:0] readdata,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        halt_req,
`ifdef IFETCH_PERF_EN
   output logic [31:0] stall_cnt,
   output logic [31:0] bubble_cnt,
`endif
   output logic        fetch_err
);

   localparam int unsigned OccW = $clog2(FB_DEPTH + 1);

   typedef enum logic [1:0] {StIdle, StRun, StHalt, StErr} state_e;

   state_e            state_q, state_d;
   logic [31:0]       pc_q, pc_d;
   logic [31:0]       addr_q, addr_d;
   logic              epoch_q, epoch_d;
   logic              fetch_err_q, fetch_err_d;
   logic              inflight_q, inflight_d;
   logic              tag_q, tag_d;
   logic [31:0]       ret_pc_q, ret_pc_d;
   logic [OccW-1:0]   occ_q, occ_d, wr_idx;
   logic [31:0]       fb_instr_q [FB_DEPTH];
   logic [31:0]       fb_instr_d [FB_DEPTH];
   logic [31:0]       fb_pc_q    [FB_DEPTH];
   logic [31:0]       fb_pc_d    [FB_DEPTH];

   logic              issue, redirect_eff, has_credit, pc_oor, tgt_oor;
   logic              ret_live, push, pop, bypass;
   logic [31:0]       tgt;

   assign tgt          = redirect_pc & 32'hFFFF_FFFC;
   assign tgt_oor      = tgt >= ADDR_LIMIT;
   assign pc_oor       = pc_q >= ADDR_LIMIT;
   assign redirect_eff = redirect_valid && (state_q != StIdle);
   // Every outstanding read must have a buffer slot reserved for its return.
   assign has_credit   = (32'(occ_q) + 32'(inflight_q)) < FB_DEPTH;

   // A return from before the latest redirect carries a stale epoch and is dropped.
   assign ret_live = inflight_q && (tag_q == epoch_q);
   assign push     = ret_live && !redirect_eff;
   // Empty buffer: the returning word is shown directly so a redirect costs only two cycles.
   assign bypass   = (occ_q == '0) && ret_live;
   assign if_valid = (occ_q != '0) || ret_live;
   assign if_instr = bypass ? readdata : fb_instr_q[0];
   assign if_pc    = bypass ? ret_pc_q : fb_pc_q[0];
   assign pop      = if_valid && if_ready;

   assign memread   = issue;
   assign address   = issue ? pc_q : addr_q;
   assign fetch_err = fetch_err_q;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      epoch_d     = epoch_q;
      fetch_err_d = fetch_err_q;
      issue       = 1'b0;
      if (state_q == StIdle) begin
         state_d = StRun;
      end else if (redirect_eff) begin
         pc_d        = tgt;
         epoch_d     = ~epoch_q;
         fetch_err_d = tgt_oor;
         state_d     = tgt_oor ? StErr : StRun;
      end else begin
         case (state_q)
            StRun: begin
               if (halt_req) begin
                  state_d = StHalt;
               end else if (pc_oor) begin
                  state_d     = StErr;
                  fetch_err_d = 1'b1;
               end else if (has_credit) begin
                  issue = 1'b1;
                  pc_d  = pc_q + 32'd4;
               end
            end
            StHalt: if (!halt_req) state_d = StRun;
            default: ;
         endcase
      end
      inflight_d = issue;
      tag_d      = issue ? epoch_q : tag_q;
      ret_pc_d   = issue ? pc_q : ret_pc_q;
      addr_d     = address;
   end

   // Fetch buffer kept as a shift queue; entry 0 is the head.
   always_comb begin
      fb_instr_d = fb_instr_q;
      fb_pc_d    = fb_pc_q;
      wr_idx     = occ_q;
      occ_d      = occ_q;
      if (redirect_eff) begin
         occ_d = '0;
      end else begin
         if (pop && (occ_q != '0)) begin
            for (int i = 0; i < int'(FB_DEPTH) - 1; i++) begin
               fb_instr_d[i] = fb_instr_q[i+1];
               fb_pc_d[i]    = fb_pc_q[i+1];
            end
            wr_idx = occ_q - OccW'(1);
         end
         // A bypassed word taken by decode in its return cycle is never stored.
         if (push && !(pop && (occ_q == '0))) begin
            for (int i = 0; i < int'(FB_DEPTH); i++) begin
               if (OccW'(i) == wr_idx) begin
                  fb_instr_d[i] = readdata;
                  fb_pc_d[i]    = ret_pc_q;
               end
            end
            occ_d = wr_idx + OccW'(1);
         end else begin
            occ_d = wr_idx;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         pc_q        <= RESET_PC;
         addr_q      <= RESET_PC;
         epoch_q     <= 1'b0;
         fetch_err_q <= 1'b0;
         inflight_q  <= 1'b0;
         tag_q       <= 1'b0;
         ret_pc_q    <= '0;
         occ_q       <= '0;
         for (int i = 0; i < int'(FB_DEPTH); i++) begin
            fb_instr_q[i] <= '0;
            fb_pc_q[i]    <= '0;
         end
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         addr_q      <= addr_d;
         epoch_q     <= epoch_d;
         fetch_err_q <= fetch_err_d;
         inflight_q  <= inflight_d;
         tag_q       <= tag_d;
         ret_pc_q    <= ret_pc_d;
         occ_q       <= occ_d;
         fb_instr_q  <= fb_instr_d;
         fb_pc_q     <= fb_pc_d;
      end
   end

`ifdef IFETCH_PERF_EN
   logic [31:0] stall_cnt_q, stall_cnt_d, bubble_cnt_q, bubble_cnt_d;

   always_comb begin
      stall_cnt_d  = stall_cnt_q;
      bubble_cnt_d = bubble_cnt_q;
      if (if_valid && !if_ready && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
      if ((state_q == StRun) && !if_valid && if_ready && (bubble_cnt_q != '1)) begin
         bubble_cnt_d = bubble_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         stall_cnt_q  <= stall_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign stall_cnt  = stall_cnt_q;
   assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Testbench for imem_fetch_ctrl: bank model, directed scenarios, then randomized traffic.
// The reference model is the architectural instruction stream: sequential words from the current
// start address up to the bank limit, restarted at every redirect or reset.
module tb_imem_fetch_ctrl;
   localparam int unsigned FB_DEPTH   = 2;
   localparam int unsigned ADDR_LIMIT = 1024;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        memread;
   logic [31:0] address;
   logic [31:0] readdata = '0;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        halt_req;
   logic        fetch_err;
`ifdef IFETCH_PERF_EN
   logic [31:0] stall_cnt, bubble_cnt;
`endif

   imem_fetch_ctrl #(
      .RESET_PC  (32'h0000_0000),
      .FB_DEPTH  (FB_DEPTH),
      .ADDR_LIMIT(ADDR_LIMIT)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .memread       (memread),
      .address       (address),
      .readdata      (readdata),
      .if_valid      (if_valid),
      .if_ready      (if_ready),
      .if_instr      (if_instr),
      .if_pc         (if_pc),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .halt_req      (halt_req),
`ifdef IFETCH_PERF_EN
      .stall_cnt     (stall_cnt),
      .bubble_cnt    (bubble_cnt),
`endif
      .fetch_err     (fetch_err)
   );

   always #5 clk = ~clk;

   // Bank: registered read, data visible the cycle after memread.
   logic [31:0] mem [256];
   always @(posedge clk) if (memread) readdata <= mem[address[9:2]];

   int n_cmp = 0;
   int n_err = 0;
   int n_acc = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- scoreboard ----------------
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] nxt_pc = '0;
   logic        prev_hold = 1'b0;
   logic [31:0] prev_pc, prev_instr;

   function automatic void refill();
      while (exp_q.size() < 8 && nxt_pc < ADDR_LIMIT) begin
         exp_q.push_back('{pc: nxt_pc, instr: mem[nxt_pc[9:2]]});
         nxt_pc = nxt_pc + 32'd4;
      end
   endfunction

   always @(negedge clk) begin : monitor
      exp_t e;
      if (!rst_n) begin
         exp_q.delete();
         nxt_pc    = 32'h0;
         prev_hold = 1'b0;
      end else begin
         if (prev_hold) begin
            chk("hold_valid", 32'(if_valid), 32'd1);
            chk("hold_pc", if_pc, prev_pc);
            chk("hold_instr", if_instr, prev_instr);
         end
         if (if_valid && if_ready) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL deliver: got pc %h, required no delivery", if_pc);
            end else begin
               e = exp_q.pop_front();
               chk("deliver_pc", if_pc, e.pc);
               chk("deliver_instr", if_instr, e.instr);
               n_acc++;
            end
         end
         if (redirect_valid) begin
            exp_q.delete();
            nxt_pc = redirect_pc & 32'hFFFF_FFFC;
         end
         if (memread) begin
            chk("rd_in_range", 32'(address < ADDR_LIMIT), 32'd1);
            chk("rd_align", 32'(address[1:0]), 32'd0);
         end
         refill();
         prev_hold  = if_valid && !if_ready && !redirect_valid;
         prev_pc    = if_pc;
         prev_instr = if_instr;
      end
   end

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_memread"}, 32'(memread), 32'd0);
      chk({tag, "_address"}, address, 32'h0);
      chk({tag, "_if_valid"}, 32'(if_valid), 32'd0);
      chk({tag, "_if_instr"}, if_instr, 32'h0);
      chk({tag, "_if_pc"}, if_pc, 32'h0);
      chk({tag, "_fetch_err"}, 32'(fetch_err), 32'd0);
   endtask

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int   rd_cnt;
      logic ok;
`ifdef IFETCH_PERF_EN
      logic [31:0] s0;
`endif
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      if_ready       = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      halt_req       = 1'b0;

      // Reset values, then release mid-cycle: one dead cycle, first read next cycle.
      repeat (2) @(posedge clk);
      #1;
      chk_reset_outputs("reset");
      step();
      rst_n = 1'b1;
      @(negedge clk);
      chk("dead_memread", 32'(memread), 32'd0);
      @(negedge clk);
      chk("first_memread", 32'(memread), 32'd1);
      chk("first_address", address, 32'h0);
      chk("first_valid", 32'(if_valid), 32'd0);
      @(negedge clk);
      chk("second_address", address, 32'h4);
      chk("first_if_valid", 32'(if_valid), 32'd1);
      chk("first_if_pc", if_pc, 32'h0);
      @(negedge clk);
      chk("second_if_pc", if_pc, 32'h4);

      // Decode stalls 5 cycles: reads bounded by buffer depth.
      step();
      if_ready = 1'b0;
      rd_cnt   = 0;
      repeat (5) begin
         @(negedge clk);
         if (memread) rd_cnt++;
      end
      chk("stall_reads_bounded", 32'(rd_cnt <= FB_DEPTH), 32'd1);
      chk("stall_full_valid", 32'(if_valid), 32'd1);

      // Redirect to unaligned 0x13 while the buffer is full.
      step();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0013;
      if_ready       = 1'b1;
      step();
      redirect_valid = 1'b0;
      @(negedge clk);
      chk("redir_memread", 32'(memread), 32'd1);
      chk("redir_address", address, 32'h10);
      chk("redir_flushed", 32'(if_valid), 32'd0);
      step();
      @(negedge clk);
      chk("redir_if_valid", 32'(if_valid), 32'd1);
      chk("redir_if_pc", if_pc, 32'h10);

      // Last word of the bank, then out-of-range error.
      step();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_03FC;
      step();
      redirect_valid = 1'b0;
      @(negedge clk);
      chk("end_address", address, 32'h3FC);
      step();
      @(negedge clk);
      chk("end_if_pc", if_pc, 32'h3FC);
      chk("end_if_valid", 32'(if_valid), 32'd1);
      step();
      @(negedge clk);
      chk("err_set", 32'(fetch_err), 32'd1);
      repeat (3) begin
         @(negedge clk);
         chk("err_no_read", 32'(memread), 32'd0);
      end
      step();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0;
      step();
      redirect_valid = 1'b0;
      @(negedge clk);
      chk("err_cleared", 32'(fetch_err), 32'd0);
      chk("err_resume_rd", 32'(memread), 32'd1);
      chk("err_resume_addr", address, 32'h0);

      // Halt for 4 cycles mid-stream.
      repeat (4) step();
      halt_req = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("halt_no_read", 32'(memread), 32'd0);
         if (k == 0) chk("halt_inflight", 32'(if_valid), 32'd1);
         if (k < 3) step();
      end
      step();
      halt_req = 1'b0;
      ok = 1'b0;
      for (int k = 0; k < 10 && !ok; k++) begin
         @(negedge clk);
         if (memread) ok = 1'b1;
      end
      chk("halt_resume", 32'(ok), 32'd1);

      // Asynchronous reset mid-stream.
      repeat (3) step();
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("midreset");
      repeat (2) step();
      rst_n = 1'b1;
      repeat (4) step();

`ifdef IFETCH_PERF_EN
      chk("perf_pre_valid", 32'(if_valid), 32'd1);
      s0       = stall_cnt;
      if_ready = 1'b0;
      repeat (7) step();
      chk("perf_stall_delta", stall_cnt - s0, 32'd7);
      if_ready = 1'b1;
`endif

      // Randomized traffic.
      for (int c = 0; c < 1500; c++) begin
         step();
         if_ready       = ($urandom_range(0, 3) != 0);
         redirect_valid = 1'b0;
         if ($urandom_range(0, 19) == 0) halt_req = ~halt_req;
         if ($urandom_range(0, 29) == 0) begin
            redirect_valid = 1'b1;
            case ($urandom_range(0, 3))
               0:       redirect_pc = 32'h3F0 + $urandom_range(0, 15);
               1:       redirect_pc = 32'h800 | $urandom_range(0, 3);
               default: redirect_pc = $urandom_range(0, 1023);
            endcase
         end
      end
      step();
      redirect_valid = 1'b0;
      halt_req       = 1'b0;
      if_ready       = 1'b1;
      repeat (10) step();
      chk("progress", 32'(n_acc > 150), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
